cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_exc_arbiter.sv | 31 +++
 rtl/cp0_unit.sv | 106 ++++++++++
 tb/tb_cp0_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 coprocessor: register numbers, exception
// codes and the bit positions of the SR and Cause fields.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IM_HI       = 15;
  localparam int SR_IM_LO       = 10;
  localparam int SR_EXL         = 1;
  localparam int SR_IE          = 0;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_IP_HI    = 15;
  localparam int CAUSE_IP_LO    = 10;
  localparam int CAUSE_EXC_HI   = 6;
  localparam int CAUSE_EXC_LO   = 2;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Decides whether an interrupt or a synchronous exception is taken this cycle
// and which exception code gets recorded.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic       exc,
  input  logic [4:0] exc_code,
  output logic       flush,
  output logic [4:0] sel_code
);

  logic int_req_s;
  logic exc_req_s;

  // Interrupts outrank the exception on the same instruction.
  always_comb begin
    int_req_s = ie & ~exl & (|(hw_int & im));
    exc_req_s = exc & ~exl;
    flush     = int_req_s | exc_req_s;
    if (int_req_s) begin
      sel_code = EXC_INT;
    end else begin
      sel_code = exc_code;
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC, PrID) with exception entry, eret and
// mtc0/mfc0 access for a five-stage MIPS-style pipeline.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h4D495053,
  parameter logic [31:0] HANDLER_PC = 32'h00004180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        CP0Write_M,
  input  logic        Eret_M,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic        Exc_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  output logic        EXC_flush,
  output logic [31:0] HandlerPC,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r;
  logic [29:0] epc_r;

  logic        flush_s;
  logic [4:0]  sel_code_s;
  logic [29:0] epc_next_s;
  logic [31:0] dout_s;
  logic [1:0]  unused_pc_s;

  cp0_exc_arbiter u_arb (
    .ie       (ie_r),
    .exl      (exl_r),
    .im       (im_r),
    .hw_int   (HWInt),
    .exc      (Exc_M),
    .exc_code (ExcCode_M),
    .flush    (flush_s),
    .sel_code (sel_code_s)
  );

  // EPC is word aligned, so the delay-slot rewind is a decrement of the word index.
  assign epc_next_s  = BD_M ? (PC_M[31:2] - 30'd1) : PC_M[31:2];
  assign unused_pc_s = PC_M[1:0];

  // State update: reset, then exception entry, then mtc0 followed by eret.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_r       <= 6'd0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ip_r       <= 6'd0;
      exc_code_r <= 5'd0;
      epc_r      <= 30'd0;
    end else begin
      ip_r <= HWInt;
      if (flush_s) begin
        exl_r      <= 1'b1;
        bd_r       <= BD_M;
        exc_code_r <= sel_code_s;
        epc_r      <= epc_next_s;
      end else begin
        if (CP0Write_M && (A2 == REG_SR)) begin
          im_r  <= DIn[SR_IM_HI:SR_IM_LO];
          exl_r <= DIn[SR_EXL];
          ie_r  <= DIn[SR_IE];
        end
        if (CP0Write_M && (A2 == REG_EPC)) begin
          epc_r <= DIn[31:2];
        end
        if (Eret_M) begin
          exl_r <= 1'b0;
        end
      end
    end
  end

  // mfc0 read port; reflects the registered state only.
  always_comb begin
    dout_s = 32'h0000_0000;
    case (A1)
      REG_SR:    dout_s = {16'h0000, im_r, 8'h00, exl_r, ie_r};
      REG_CAUSE: dout_s = {bd_r, 15'h0000, ip_r, 3'b000, exc_code_r, 2'b00};
      REG_EPC:   dout_s = {epc_r, 2'b00};
      REG_PRID:  dout_s = PRID;
      default:   dout_s = 32'h0000_0000;
    endcase
  end

  assign EXC_flush = flush_s;
  assign HandlerPC = HANDLER_PC;
  assign EPC_out   = {epc_r, 2'b00};
  assign DOut      = dout_s;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus a randomized run,
// all compared against a word-level behavioural model of SR/Cause/EPC.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V    = 32'h4D495053;
  localparam logic [31:0] HANDLER_V = 32'h00004180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode_M;
  logic [31:0] DIn, PC_M;
  logic        CP0Write_M, Eret_M, BD_M, Exc_M;
  logic [5:0]  HWInt;
  logic        EXC_flush;
  logic [31:0] HandlerPC, EPC_out, DOut;

  int checks = 0;
  int errors = 0;

  // Model state as full architectural words.
  logic [31:0] sr_m, cause_m, epc_m;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn),
    .CP0Write_M(CP0Write_M), .Eret_M(Eret_M), .PC_M(PC_M), .BD_M(BD_M),
    .Exc_M(Exc_M), .ExcCode_M(ExcCode_M), .HWInt(HWInt),
    .EXC_flush(EXC_flush), .HandlerPC(HandlerPC), .EPC_out(EPC_out), .DOut(DOut)
  );

  always #5 clk = ~clk;

  function automatic logic model_flush();
    logic in_handler;
    in_handler = sr_m[1];
    if (in_handler) return 1'b0;
    if (Exc_M) return 1'b1;
    return sr_m[0] && ((HWInt & sr_m[15:10]) != 6'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    case (r)
      5'd12:   return sr_m;
      5'd13:   return cause_m;
      5'd14:   return epc_m;
      5'd15:   return PRID_V;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: evaluate the model on the current inputs, apply at the edge.
  task automatic tick();
    logic [31:0] nsr, ncause, nepc;
    logic irq, take;
    nsr = sr_m; ncause = cause_m; nepc = epc_m;
    take = model_flush();
    irq  = !sr_m[1] && sr_m[0] && ((HWInt & sr_m[15:10]) != 6'd0);
    ncause[15:10] = HWInt;
    if (take) begin
      nsr[1] = 1'b1;
      ncause[31] = BD_M;
      ncause[6:2] = irq ? 5'd0 : ExcCode_M;
      nepc = (BD_M ? PC_M - 32'd4 : PC_M) & 32'hFFFF_FFFC;
    end else begin
      if (CP0Write_M && A2 == 5'd12) nsr = DIn & 32'h0000_FC03;
      if (CP0Write_M && A2 == 5'd14) nepc = DIn & 32'hFFFF_FFFC;
      if (Eret_M) nsr[1] = 1'b0;
    end
    if (reset) begin
      nsr = 32'h0; ncause = 32'h0; nepc = 32'h0;
    end
    @(posedge clk);
    sr_m = nsr; cause_m = ncause; epc_m = nepc;
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0;
    CP0Write_M = 1'b0; Eret_M = 1'b0; PC_M = 32'h0; BD_M = 1'b0;
    Exc_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int r = 12; r <= 15; r++) begin
      A1 = r[4:0]; #1;
      checks++;
      if (DOut !== model_read(r[4:0])) begin
        errors++; $display("FAIL reset_read r%0d got %h exp %h", r, DOut, model_read(r[4:0]));
      end
    end
    checks++;
    if (EXC_flush !== 1'b0 || HandlerPC !== HANDLER_V || EPC_out !== 32'h0) begin
      errors++; $display("FAIL reset_outs flush=%b hpc=%h epc=%h exp 0/%h/0", EXC_flush, HandlerPC, EPC_out, HANDLER_V);
    end
    A1 = 5'd3; #1;
    checks++;
    if (DOut !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", DOut); end
  endtask

  task automatic test_mtc0();
    do_reset();
    CP0Write_M = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF; A1 = 5'd14; #1;
    checks++;
    if (DOut !== 32'h0) begin errors++; $display("FAIL no_bypass got %h exp 0", DOut); end
    tick();
    A2 = 5'd13; DIn = 32'hFFFF_FFFF; tick();
    A2 = 5'd15; tick();
    CP0Write_M = 1'b0; #1;
    checks++;
    if (EPC_out !== 32'hDEAD_BEEC) begin errors++; $display("FAIL epc_write got %h exp deadbeec", EPC_out); end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0) begin errors++; $display("FAIL cause_ro got %h exp 0", DOut); end
    A1 = 5'd15; #1;
    checks++;
    if (DOut !== PRID_V) begin errors++; $display("FAIL prid_ro got %h exp %h", DOut, PRID_V); end
    CP0Write_M = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF; tick();
    CP0Write_M = 1'b0; A1 = 5'd12; HWInt = 6'h3F; #1;
    checks++;
    if (DOut !== 32'h0000_FC03 || EXC_flush !== 1'b0) begin
      errors++; $display("FAIL sr_write sr=%h flush=%b exp 0000fc03/0", DOut, EXC_flush);
    end
  endtask

  task automatic test_interrupt();
    do_reset();
    CP0Write_M = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01; tick();
    CP0Write_M = 1'b0; HWInt = 6'b000100; PC_M = 32'h0000_2000; #1;
    checks++;
    if (EXC_flush !== 1'b1) begin errors++; $display("FAIL int_flush got %b exp 1", EXC_flush); end
    tick();
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_1000) begin errors++; $display("FAIL int_cause got %h exp 00001000", DOut); end
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC03 || EPC_out !== 32'h0000_2000) begin
      errors++; $display("FAIL int_sr_epc sr=%h epc=%h exp 0000fc03/00002000", DOut, EPC_out);
    end
  endtask

  task automatic test_exception_bd();
    do_reset();
    Exc_M = 1'b1; ExcCode_M = 5'd12; BD_M = 1'b1; PC_M = 32'h0000_3010; #1;
    checks++;
    if (EXC_flush !== 1'b1) begin errors++; $display("FAIL exc_flush got %b exp 1", EXC_flush); end
    tick();
    Exc_M = 1'b0; BD_M = 1'b0; A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h8000_0030 || EPC_out !== 32'h0000_300C) begin
      errors++; $display("FAIL exc_bd cause=%h epc=%h exp 80000030/0000300c", DOut, EPC_out);
    end
  endtask

  // Continues from the handler state left by test_exception_bd.
  task automatic test_exl_block_eret();
    CP0Write_M = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03; tick();
    CP0Write_M = 1'b0; Exc_M = 1'b1; ExcCode_M = 5'd10; HWInt = 6'b000001; PC_M = 32'h0000_7000; #1;
    checks++;
    if (EXC_flush !== 1'b0) begin errors++; $display("FAIL exl_block got %b exp 0", EXC_flush); end
    tick();
    Exc_M = 1'b0; #1;
    checks++;
    if (EPC_out !== 32'h0000_300C) begin errors++; $display("FAIL exl_epc got %h exp 0000300c", EPC_out); end
    Eret_M = 1'b1; #1;
    checks++;
    if (EXC_flush !== 1'b0) begin errors++; $display("FAIL eret_noflush got %b exp 0", EXC_flush); end
    tick();
    Eret_M = 1'b0; PC_M = 32'h0000_4000; A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC01 || EXC_flush !== 1'b1) begin
      errors++; $display("FAIL eret_then_int sr=%h flush=%b exp 0000fc01/1", DOut, EXC_flush);
    end
    tick();
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_0400 || EPC_out !== 32'h0000_4000) begin
      errors++; $display("FAIL pending_int cause=%h epc=%h exp 00000400/00004000", DOut, EPC_out);
    end
  endtask

  task automatic test_exc_vs_mtc0();
    do_reset();
    Exc_M = 1'b1; ExcCode_M = 5'd4; PC_M = 32'h0000_5000;
    CP0Write_M = 1'b1; A2 = 5'd14; DIn = 32'h1234_5678; tick();
    idle_inputs(); #1;
    checks++;
    if (EPC_out !== 32'h0000_5000) begin errors++; $display("FAIL exc_wins got %h exp 00005000", EPC_out); end
  endtask

  // Enters reset while still in the handler from test_exc_vs_mtc0.
  task automatic test_reset_mid_handler();
    reset = 1'b1; Exc_M = 1'b1; Eret_M = 1'b1; CP0Write_M = 1'b1; A2 = 5'd12; DIn = 32'hFFFF;
    HWInt = 6'h3F; tick();
    idle_inputs(); HWInt = 6'h3F; Exc_M = 1'b0;
    for (int r = 12; r <= 14; r++) begin
      A1 = r[4:0]; #1;
      checks++;
      if (DOut !== 32'h0) begin errors++; $display("FAIL reset_mid r%0d got %h exp 0", r, DOut); end
    end
    A1 = 5'd15; #1;
    checks++;
    if (DOut !== PRID_V || EXC_flush !== 1'b0) begin
      errors++; $display("FAIL reset_mid_prid got %h flush=%b exp %h/0", DOut, EXC_flush, PRID_V);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] regs [4];
    regs[0] = 5'd12; regs[1] = 5'd13; regs[2] = 5'd14; regs[3] = 5'd15;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      A1         = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 3)];
      A2         = ($urandom_range(0, 5) == 0) ? 5'($urandom) : regs[$urandom_range(0, 3)];
      DIn        = $urandom;
      CP0Write_M = ($urandom_range(0, 3) == 0);
      Eret_M     = ($urandom_range(0, 7) == 0);
      PC_M       = $urandom;
      BD_M       = $urandom_range(0, 1);
      Exc_M      = ($urandom_range(0, 9) == 0);
      ExcCode_M  = 5'($urandom);
      HWInt      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      #1;
      checks++;
      if (EXC_flush !== model_flush()) begin
        errors++; $display("FAIL rand_flush cyc %0d got %b exp %b", i, EXC_flush, model_flush());
      end
      checks++;
      if (DOut !== model_read(A1) || EPC_out !== epc_m) begin
        errors++; $display("FAIL rand_read cyc %0d a1=%0d got %h/%h exp %h/%h", i, A1, DOut, EPC_out, model_read(A1), epc_m);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    sr_m = 32'h0; cause_m = 32'h0; epc_m = 32'h0;
    #1;
    test_reset();
    test_mtc0();
    test_interrupt();
    test_exception_bd();
    test_exl_block_eret();
    test_exc_vs_mtc0();
    test_reset_mid_handler();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
